// File: rtl/alu_seq_if.sv
// Request/response bundle between a sequencer (master) and the alu_seq execution unit (slave).
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, zero, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, zero, overflow, div_by_zero
    );
endinterface

// File: rtl/alu_seq.sv
// Single-outstanding-operation ALU: one-cycle logic/arith ops, bit-serial MUL and DIV,
// result and flags held in DONE until the consumer takes them.
//
// state  | meaning
// S_IDLE | waiting for a request, in_ready=1
// S_MUL  | shift-add multiply, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
// S_DONE | out_valid=1, result/flags frozen until out_ready
module alu_seq #(
    parameter int WIDTH = 8
) (
    input logic    clk,
    input logic    rst_n,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_ROL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_NAND = 4'd12;
    localparam logic [3:0] OP_XNOR = 4'd13;
    localparam logic [3:0] OP_GT   = 4'd14;
    localparam logic [3:0] OP_EQ   = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] work;
    logic [WIDTH-1:0]   opb;
    logic [CW-1:0]      cnt;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic               zero_q;
    logic               overflow_q;
    logic               dbz_q;

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic               alu_dbz;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    assign bus.in_ready    = (state == S_IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.carry       = carry_q;
    assign bus.zero        = zero_q;
    assign bus.overflow    = overflow_q;
    assign bus.div_by_zero = dbz_q;

    always_comb begin
        sum_ext   = {1'b0, bus.a} + {1'b0, bus.b};
        diff      = bus.a - bus.b;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_dbz   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff;
                alu_carry = (bus.a < bus.b);
                alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            // Only reached as a one-cycle op when the divisor is zero.
            OP_DIV: begin
                alu_res = '1;
                alu_dbz = 1'b1;
            end
            OP_SHL: begin
                alu_res   = {bus.a[WIDTH-2:0], 1'b0};
                alu_carry = bus.a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res   = {1'b0, bus.a[WIDTH-1:1]};
                alu_carry = bus.a[0];
            end
            OP_ROL:  alu_res = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
            OP_ROR:  alu_res = {bus.a[0], bus.a[WIDTH-1:1]};
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_NAND: alu_res = ~(bus.a & bus.b);
            OP_XNOR: alu_res = ~(bus.a ^ bus.b);
            OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (bus.a > bus.b)};
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            default: alu_res = '0;
        endcase
    end

    // work holds {partial product high, multiplier} for MUL and {remainder, dividend} for DIV.
    always_comb begin
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opb} : '0);
        mul_next  = {mul_sum, work[WIDTH-1:1]};
        div_shift = work[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opb});
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opb) : div_shift[WIDTH-1:0];
        div_next  = {div_rem, work[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            work        <= '0;
            opb         <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        work <= {{WIDTH{1'b0}}, bus.a};
                        opb  <= bus.b;
                        cnt  <= CW'(WIDTH-1);
                        if (bus.op == OP_MUL) begin
                            state <= S_MUL;
                        end else if (bus.op == OP_DIV && bus.b != '0) begin
                            state <= S_DIV;
                        end else begin
                            state       <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res;
                            carry_q     <= alu_carry;
                            zero_q      <= (alu_res == '0);
                            overflow_q  <= alu_ovf;
                            dbz_q       <= alu_dbz;
                        end
                    end
                end
                S_MUL: begin
                    work <= mul_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state       <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= mul_next[WIDTH-1:0];
                        carry_q     <= |mul_next[2*WIDTH-1:WIDTH];
                        zero_q      <= (mul_next[WIDTH-1:0] == '0);
                        overflow_q  <= 1'b0;
                        dbz_q       <= 1'b0;
                    end
                end
                S_DIV: begin
                    work <= div_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state       <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= div_next[WIDTH-1:0];
                        carry_q     <= 1'b0;
                        zero_q      <= (div_next[WIDTH-1:0] == '0);
                        overflow_q  <= 1'b0;
                        dbz_q       <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: directed vector table, random ops against an arithmetic
// model, plus backpressure and mid-operation reset sequences.
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       v;
        logic       d;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic, signed overflow via range test.
    function automatic void model(input int op, input int a, input int b,
                                  output int res, output int c, output int z,
                                  output int v, output int d, output int lat);
        int sa, sb, s;
        sa  = (a >= 128) ? a - 256 : a;
        sb  = (b >= 128) ? b - 256 : b;
        res = 0; c = 0; v = 0; d = 0; lat = 1;
        case (op)
            0: begin res = (a + b) % 256; c = (a + b > 255); s = sa + sb; v = (s > 127 || s < -128); end
            1: begin res = (a - b + 256) % 256; c = (a < b); s = sa - sb; v = (s > 127 || s < -128); end
            2: begin res = (a * b) % 256; c = (a * b > 255); lat = 9; end
            3: begin
                if (b == 0) begin res = 255; d = 1; end
                else begin res = a / b; lat = 9; end
            end
            4: begin res = (a * 2) % 256; c = (a >= 128); end
            5: begin res = a / 2; c = a % 2; end
            6: res = (a * 2) % 256 + a / 128;
            7: res = a / 2 + (a % 2) * 128;
            8: res = a & b;
            9: res = a | b;
            10: res = a ^ b;
            11: res = 255 - (a | b);
            12: res = 255 - (a & b);
            13: res = 255 - (a ^ b);
            14: res = (a > b) ? 1 : 0;
            default: res = (a == b) ? 1 : 0;
        endcase
        z = (res == 0);
    endfunction

    task automatic do_op(input string name, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int e_res, input int e_c, input int e_z,
                         input int e_v, input int e_d, input int e_lat);
        int wait_cnt;
        int lat;
        int ready_leak;
        wait_cnt = 0;
        while (!bus.in_ready && wait_cnt < 100) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        if (!bus.in_ready) begin
            check({name, ".idle_timeout"}, 0, 1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        bus.op       = 4'($urandom);
        lat        = 1;
        ready_leak = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) ready_leak++;
            @(posedge clk); #1;
            lat++;
        end
        check({name, ".lat"}, lat, e_lat);
        check({name, ".busy_ready"}, ready_leak + int'(bus.in_ready), 0);
        check({name, ".res"}, int'(bus.result), e_res);
        check({name, ".carry"}, int'(bus.carry), e_c);
        check({name, ".zero"}, int'(bus.zero), e_z);
        check({name, ".ovf"}, int'(bus.overflow), e_v);
        check({name, ".dbz"}, int'(bus.div_by_zero), e_d);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, ".release"}, int'({bus.in_ready, bus.out_valid}), 2);
    endtask

    initial begin
        int r, c, z, v, d, lat;
        int ov_cnt;
        logic [3:0] rop;
        logic [7:0] ra, rb;

        total = 0;
        bad   = 0;

        vecs.push_back('{"add_wrap",  4'd0,  8'hF6, 8'h0A, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{"sub",       4'd1,  8'h0A, 8'h02, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"add_ovf",   4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{"sub_ovf",   4'd1,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{"sub_borrow",4'd1,  8'h02, 8'h05, 8'hFD, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"mul_small", 4'd2,  8'h0A, 8'h02, 8'h14, 1'b0, 1'b0, 1'b0, 1'b0, 9});
        vecs.push_back('{"mul_big",   4'd2,  8'hF6, 8'h0A, 8'h9C, 1'b1, 1'b0, 1'b0, 1'b0, 9});
        vecs.push_back('{"div",       4'd3,  8'hF6, 8'h0A, 8'h18, 1'b0, 1'b0, 1'b0, 1'b0, 9});
        vecs.push_back('{"div_zero_q",4'd3,  8'h03, 8'h07, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 9});
        vecs.push_back('{"div_by0",   4'd3,  8'h55, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{"shl",       4'd4,  8'h81, 8'h02, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"shr",       4'd5,  8'h81, 8'h02, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"rol",       4'd6,  8'h81, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"ror",       4'd7,  8'h81, 8'h02, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"and",       4'd8,  8'h81, 8'h02, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{"or",        4'd9,  8'h81, 8'h02, 8'h83, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"xor",       4'd10, 8'h81, 8'h02, 8'h83, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"nor",       4'd11, 8'h81, 8'h02, 8'h7C, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"nand",      4'd12, 8'h81, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"xnor",      4'd13, 8'h81, 8'h02, 8'h7C, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"gt",        4'd14, 8'h81, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"eq",        4'd15, 8'h81, 8'h02, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1});

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        rst_n         = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", int'(bus.in_ready), 1);
        check("rst.outs", int'({bus.out_valid, bus.result, bus.carry, bus.zero,
                                bus.overflow, bus.div_by_zero}), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, int'(vecs[i].res),
                  int'(vecs[i].c), int'(vecs[i].z), int'(vecs[i].v), int'(vecs[i].d),
                  vecs[i].lat);

        for (int i = 0; i < 250; i++) begin
            rop = 4'($urandom);
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            model(int'(rop), int'(ra), int'(rb), r, c, z, v, d, lat);
            do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, r, c, z, v, d, lat);
        end

        // Backpressure: result held while a new request and noisy operands are presented.
        do_op("bp_pre", 4'd1, 8'h05, 8'h01, 8'h04, 0, 0, 0, 0, 1);
        bus.in_valid = 1'b1;
        bus.a        = 8'h30;
        bus.b        = 8'h40;
        bus.op       = 4'd0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            bus.a  = 8'($urandom);
            bus.b  = 8'($urandom);
            bus.op = 4'($urandom);
            check($sformatf("bp%0d.valid_ready", k), int'({bus.out_valid, bus.in_ready}), 2);
            check($sformatf("bp%0d.res", k), int'(bus.result), 8'h70);
            check($sformatf("bp%0d.flags", k),
                  int'({bus.carry, bus.zero, bus.overflow, bus.div_by_zero}), 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("bp.release_ready", int'(bus.in_ready), 1);
        check("bp.release_valid", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        check("bp.no_extra_accept", int'({bus.in_ready, bus.out_valid}), 2);

        // Reset pulse in the middle of a divide.
        bus.in_valid = 1'b1;
        bus.a        = 8'hF6;
        bus.b        = 8'h0A;
        bus.op       = 4'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_div.busy", int'(bus.in_ready), 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst.outs", int'({bus.out_valid, bus.result, bus.carry, bus.zero,
                                    bus.overflow, bus.div_by_zero}), 0);
        check("mid_rst.in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        ov_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) ov_cnt++;
        end
        check("mid_rst.no_stale", ov_cnt, 0);
        do_op("post_rst_add", 4'd0, 8'h01, 8'h01, 8'h02, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
